// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit.
// An entry packs {taken, target, pc} into 65 bits.
package branch_resolve_unit_pkg;

  localparam int BR_ENTRY_W = 65;
  localparam int PC_LSB     = 0;
  localparam int TARGET_LSB = 32;
  localparam int TAKEN_BIT  = 64;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] pc;
  } br_entry_t;

endpackage

// File: rtl/branch_resolve_unit_queue.sv
// In-order FIFO of predicted branches with push, pop and a clear that wins over push.
// Storage is unreset; only the pointers and occupancy are cleared.
module branch_resolve_unit_queue
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  br_entry_t                  push_data,
  input  logic                       pop,
  input  logic                       clear,
  output br_entry_t                  head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  br_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push_ok   = push & ~full & ~clear;
  assign pop_ok    = pop & ~empty & ~clear;
  assign head_data = mem[head_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[tail_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push_ok) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop_ok)  head_ptr <= head_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares queued predictions with MEM-stage outcomes, flushes/redirects on mispredict,
// drives predictor updates and keeps branch/mispredict counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pred_valid,
  input  logic                   pred_taken,
  input  logic [31:0]            pred_pc,
  input  logic [31:0]            pred_target,
  output logic                   pred_ready,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   flush,
  output logic [31:0]            redirect_pc,
  output logic                   upd_valid,
  output logic [31:0]            upd_pc,
  output logic                   upd_taken,
  output logic [$clog2(DEPTH):0] inflight,
  output logic [CNT_W-1:0]       branch_count,
  output logic [CNT_W-1:0]       mispred_count,
  output logic                   err_underflow
);

  br_entry_t head_entry;
  br_entry_t push_entry;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      mis;

  assign pred_ready = ~full;
  assign push       = pred_valid & pred_ready;
  assign pop        = res_valid & ~empty;
  assign mis        = pop & (head_entry.taken != res_taken);
  assign push_entry = '{taken: pred_taken, target: pred_target, pc: pred_pc};

  // A mispredict clears the queue, which also drops any same-cycle enqueue.
  branch_resolve_unit_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (mis),
    .head_data (head_entry),
    .full      (full),
    .empty     (empty),
    .count     (inflight)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush         <= 1'b0;
      redirect_pc   <= '0;
      upd_valid     <= 1'b0;
      upd_pc        <= '0;
      upd_taken     <= 1'b0;
      branch_count  <= '0;
      mispred_count <= '0;
      err_underflow <= 1'b0;
    end else begin
      flush     <= mis;
      upd_valid <= pop;
      if (pop) begin
        upd_pc       <= head_entry.pc;
        upd_taken    <= res_taken;
        branch_count <= branch_count + CNT_W'(1);
      end
      if (mis) begin
        redirect_pc   <= res_taken ? head_entry.target : head_entry.pc + PC_STEP;
        mispred_count <= mispred_count + CNT_W'(1);
      end
      if (res_valid && empty) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven bench: each row is one cycle of stimulus plus the registered outputs expected after that edge.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int IW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pred_valid = 1'b0;
  logic             pred_taken = 1'b0;
  logic [31:0]      pred_pc = '0;
  logic [31:0]      pred_target = '0;
  logic             pred_ready;
  logic             res_valid = 1'b0;
  logic             res_taken = 1'b0;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [IW-1:0]    inflight;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispred_count;
  logic             err_underflow;

  int n_vec = 0;
  int n_bad = 0;

  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_pc       (pred_pc),
    .pred_target   (pred_target),
    .pred_ready    (pred_ready),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .inflight      (inflight),
    .branch_count  (branch_count),
    .mispred_count (mispred_count),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic        pt;
    logic [31:0] ppc;
    logic [31:0] ptg;
    logic        rv;
    logic        rt;
    logic        e_flush;
    logic [31:0] e_rpc;
    logic        e_uv;
    logic [31:0] e_upc;
    logic        e_ut;
    int          e_infl;
    logic        e_rdy;
    int          e_bc;
    int          e_mc;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pv, logic pt, logic [31:0] ppc, logic [31:0] ptg,
                              logic rv, logic rt, logic fl, logic [31:0] rpc, logic uv,
                              logic [31:0] upc, logic ut, int infl, logic rdy,
                              int bc, int mc, logic err);
    vec_t v;
    v.pv = pv; v.pt = pt; v.ppc = ppc; v.ptg = ptg; v.rv = rv; v.rt = rt;
    v.e_flush = fl; v.e_rpc = rpc; v.e_uv = uv; v.e_upc = upc; v.e_ut = ut;
    v.e_infl = infl; v.e_rdy = rdy; v.e_bc = bc; v.e_mc = mc; v.e_err = err;
    return v;
  endfunction

  // Compares every output against a row; one miscompare per bad row, one FAIL line per bad field.
  task automatic check_row(input string tag, input vec_t v);
    bit bad;
    bad = 0;
    n_vec++;
    if (flush !== v.e_flush) begin bad = 1; $display("FAIL %s flush got %0b want %0b", tag, flush, v.e_flush); end
    if (redirect_pc !== v.e_rpc) begin bad = 1; $display("FAIL %s redirect_pc got %h want %h", tag, redirect_pc, v.e_rpc); end
    if (upd_valid !== v.e_uv) begin bad = 1; $display("FAIL %s upd_valid got %0b want %0b", tag, upd_valid, v.e_uv); end
    if (upd_pc !== v.e_upc) begin bad = 1; $display("FAIL %s upd_pc got %h want %h", tag, upd_pc, v.e_upc); end
    if (upd_taken !== v.e_ut) begin bad = 1; $display("FAIL %s upd_taken got %0b want %0b", tag, upd_taken, v.e_ut); end
    if (inflight !== IW'(v.e_infl)) begin bad = 1; $display("FAIL %s inflight got %0d want %0d", tag, inflight, v.e_infl); end
    if (pred_ready !== v.e_rdy) begin bad = 1; $display("FAIL %s pred_ready got %0b want %0b", tag, pred_ready, v.e_rdy); end
    if (branch_count !== CNT_W'(v.e_bc)) begin bad = 1; $display("FAIL %s branch_count got %0d want %0d", tag, branch_count, v.e_bc); end
    if (mispred_count !== CNT_W'(v.e_mc)) begin bad = 1; $display("FAIL %s mispred_count got %0d want %0d", tag, mispred_count, v.e_mc); end
    if (err_underflow !== v.e_err) begin bad = 1; $display("FAIL %s err_underflow got %0b want %0b", tag, err_underflow, v.e_err); end
    if (bad) n_bad++;
    else $display("%s ok: flush=%0b rpc=%h upd=%0b/%h/%0b infl=%0d rdy=%0b bc=%0d mc=%0d err=%0b",
                  tag, flush, redirect_pc, upd_valid, upd_pc, upd_taken, inflight, pred_ready,
                  branch_count, mispred_count, err_underflow);
  endtask

  initial begin
    //              pv pt ppc           ptg           rv rt | fl rpc           uv upc           ut in rdy bc mc err
    vecs.push_back(mk(0, 0, 32'h0,        32'h0,       0, 0,  0, 32'h0,        0, 32'h0,        0, 0, 1, 0, 0, 0)); // idle after reset
    vecs.push_back(mk(1, 1, 32'h100,      32'h140,     0, 0,  0, 32'h0,        0, 32'h0,        0, 1, 1, 0, 0, 0)); // T1 enqueue
    vecs.push_back(mk(0, 0, 32'h0,        32'h0,       1, 1,  0, 32'h0,        1, 32'h100,      1, 0, 1, 1, 0, 0)); // T1 correct resolve
    vecs.push_back(mk(1, 1, 32'h200,      32'h180,     0, 0,  0, 32'h0,        0, 32'h100,      1, 1, 1, 1, 0, 0)); // T2 enqueue
    vecs.push_back(mk(0, 0, 32'h0,        32'h0,       1, 0,  1, 32'h204,      1, 32'h200,      0, 0, 1, 2, 1, 0)); // T2 mispredict not-taken
    vecs.push_back(mk(0, 0, 32'h0,        32'h0,       0, 0,  0, 32'h204,      0, 32'h200,      0, 0, 1, 2, 1, 0)); // flush is one pulse
    vecs.push_back(mk(1, 1, 32'h400,      32'h500,     0, 0,  0, 32'h204,      0, 32'h200,      0, 1, 1, 2, 1, 0)); // T3 fill
    vecs.push_back(mk(1, 0, 32'h410,      32'h300,     0, 0,  0, 32'h204,      0, 32'h200,      0, 2, 1, 2, 1, 0));
    vecs.push_back(mk(1, 1, 32'h420,      32'h520,     0, 0,  0, 32'h204,      0, 32'h200,      0, 3, 1, 2, 1, 0));
    vecs.push_back(mk(1, 1, 32'h430,      32'h530,     0, 0,  0, 32'h204,      0, 32'h200,      0, 4, 0, 2, 1, 0)); // full
    vecs.push_back(mk(1, 1, 32'h440,      32'h540,     0, 0,  0, 32'h204,      0, 32'h200,      0, 4, 0, 2, 1, 0)); // ignored while full
    vecs.push_back(mk(1, 1, 32'h440,      32'h540,     1, 1,  0, 32'h204,      1, 32'h400,      1, 3, 1, 3, 1, 0)); // full+resolve: no enqueue
    vecs.push_back(mk(1, 1, 32'h600,      32'h640,     1, 1,  1, 32'h300,      1, 32'h410,      1, 0, 1, 4, 2, 0)); // T4 mispredict taken, enqueue dropped
    vecs.push_back(mk(0, 0, 32'h0,        32'h0,       0, 0,  0, 32'h300,      0, 32'h410,      1, 0, 1, 4, 2, 0)); // queue stays empty
    vecs.push_back(mk(0, 0, 32'h0,        32'h0,       1, 1,  0, 32'h300,      0, 32'h410,      1, 0, 1, 4, 2, 1)); // T5 underflow
    vecs.push_back(mk(0, 0, 32'h0,        32'h0,       0, 0,  0, 32'h300,      0, 32'h410,      1, 0, 1, 4, 2, 1)); // sticky
    vecs.push_back(mk(1, 0, 32'h700,      32'h720,     0, 0,  0, 32'h300,      0, 32'h410,      1, 1, 1, 4, 2, 1));
    vecs.push_back(mk(1, 1, 32'h710,      32'h780,     1, 0,  0, 32'h300,      1, 32'h700,      0, 1, 1, 5, 2, 1)); // enqueue+correct: inflight same
    vecs.push_back(mk(0, 0, 32'h0,        32'h0,       1, 0,  1, 32'h714,      1, 32'h710,      0, 0, 1, 6, 3, 1)); // back-to-back update
    vecs.push_back(mk(0, 0, 32'h0,        32'h0,       0, 0,  0, 32'h714,      0, 32'h710,      0, 0, 1, 6, 3, 1));
    vecs.push_back(mk(1, 1, 32'hFFFF_FFFC, 32'h10,     0, 0,  0, 32'h714,      0, 32'h710,      0, 1, 1, 6, 3, 1));
    vecs.push_back(mk(0, 0, 32'h0,        32'h0,       1, 0,  1, 32'h0,        1, 32'hFFFF_FFFC, 0, 0, 1, 7, 4, 1)); // pc+4 wraps
    vecs.push_back(mk(0, 0, 32'h0,        32'h0,       0, 0,  0, 32'h0,        0, 32'hFFFF_FFFC, 0, 0, 1, 7, 4, 1));

    repeat (2) @(posedge clk);
    #1;
    check_row("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      pred_valid  = vecs[i].pv;
      pred_taken  = vecs[i].pt;
      pred_pc     = vecs[i].ppc;
      pred_target = vecs[i].ptg;
      res_valid   = vecs[i].rv;
      res_taken   = vecs[i].rt;
      @(posedge clk);
      #1;
      check_row($sformatf("vec%0d", i), vecs[i]);
    end

    // T6: two entries in flight with a pending update pulse, then asynchronous reset mid-cycle.
    @(negedge clk);
    pred_valid = 1'b1; pred_taken = 1'b1; pred_pc = 32'h800; pred_target = 32'h880;
    res_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    pred_pc = 32'h810;
    @(posedge clk); #1;
    check_row("t6_two_queued", mk(1, 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'hFFFF_FFFC, 0, 2, 1, 7, 4, 1));
    @(negedge clk);
    pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b1;
    @(posedge clk); #2;
    res_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_row("t6_async_reset", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_row("t6_after_release", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
